// File: rtl/nn_result_argmax.sv
// nn_result_argmax
//   Streams NUM_CLASSES IEEE-754 single-precision result words per frame and
//   reports the index and value of the largest word, plus whether any NaN
//   word was seen in the frame.
//
//   Optional feature: define NN_ARGMAX_RELU_EN to clamp every negative
//   non-NaN word to +0 before it is compared and reported.
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   synchronous active-high reset
//     in_valid   in   result word present
//     in_data    in   [31:0] single-precision result word
//     in_ready   out  word accepted this cycle (ACCUM)
//     out_valid  out  frame verdict available (HOLD)
//     out_ready  in   downstream consumes verdict
//     out_class  out  [4:0] 0-based index of the maximum word
//     out_value  out  [31:0] maximum word
//     out_nan    out  at least one NaN word in the frame
//
//   state | meaning
//   ACCUM | accepting words, tracking running max
//   HOLD  | verdict presented, upstream back-pressured
module nn_result_argmax #(
  parameter int NUM_CLASSES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_class,
  output logic [31:0] out_value,
  output logic        out_nan
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_CLASSES - 1);

  state_t      state, state_nxt;
  logic [4:0]  idx;
  logic [31:0] max_val;
  logic [4:0]  max_cls;
  logic        max_is_nan;
  logic        nan_seen;
  logic        word_xfer;
  logic        verdict_xfer;
  logic        in_is_nan;
  logic [31:0] word;

  assign in_is_nan = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);

`ifdef NN_ARGMAX_RELU_EN
  assign word = (in_data[31] && !in_is_nan) ? 32'h0 : in_data;
`else
  assign word = in_data;
`endif

  // Strictly-greater on non-NaN floats. Both zeros compare equal regardless
  // of sign, so a -0/+0 tie keeps the earlier index.
  function automatic logic greater(input logic [31:0] a, input logic [31:0] b);
    logic a_zero, b_zero;
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    if (a_zero && b_zero)
      greater = 1'b0;
    else if (!a[31] && b[31])
      greater = 1'b1;
    else if (a[31] && !b[31])
      greater = 1'b0;
    else if (!a[31])
      greater = (a[30:0] > b[30:0]);
    else
      greater = (a[30:0] < b[30:0]);
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      state <= ACCUM;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    word_xfer    = 1'b0;
    verdict_xfer = 1'b0;
    case (state)
      ACCUM: begin
        in_ready  = 1'b1;
        word_xfer = in_valid;
        if (word_xfer && (idx == LAST_IDX))
          state_nxt = HOLD;
      end
      HOLD: begin
        out_valid    = 1'b1;
        verdict_xfer = out_ready;
        if (verdict_xfer)
          state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= 5'd0;
      max_val    <= 32'h0;
      max_cls    <= 5'd0;
      max_is_nan <= 1'b0;
      nan_seen   <= 1'b0;
    end else if (word_xfer) begin
      idx <= (idx == LAST_IDX) ? 5'd0 : idx + 5'd1;
      if (idx == 5'd0) begin
        max_val    <= word;
        max_cls    <= 5'd0;
        max_is_nan <= in_is_nan;
        nan_seen   <= in_is_nan;
      end else if (in_is_nan) begin
        nan_seen <= 1'b1;
      end else if (max_is_nan || greater(word, max_val)) begin
        // A NaN held from index 0 loses to the first real word.
        max_val    <= word;
        max_cls    <= idx;
        max_is_nan <= 1'b0;
      end
    end else if (verdict_xfer) begin
      max_val    <= 32'h0;
      max_cls    <= 5'd0;
      max_is_nan <= 1'b0;
      nan_seen   <= 1'b0;
    end
  end

  assign out_class = max_cls;
  assign out_value = max_val;
  assign out_nan   = nan_seen;

endmodule

// File: tb/tb_nn_result_argmax.sv
module tb_nn_result_argmax;

  localparam int NC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_class;
  logic [31:0] out_value;
  logic        out_nan;

  int vectors = 0;
  int miscompares = 0;

  nn_result_argmax #(.NUM_CLASSES(NC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_value(out_value), .out_nan(out_nan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] frame_q[$];
  bit          m_hold = 1'b0;
  bit          m_xfer = 1'b0;
  logic [4:0]  m_cls;
  logic [31:0] m_val;
  logic        m_nan;

  function automatic bit is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 0);
  endfunction

  function automatic logic [31:0] relu(input logic [31:0] w);
`ifdef NN_ARGMAX_RELU_EN
    if (!is_nan(w) && w[31]) return 32'h0;
`endif
    return w;
  endfunction

  // Signed ordering key: sign-magnitude value, both zeros map to 0.
  function automatic longint fkey(input logic [31:0] w);
    longint m;
    m = longint'(w[30:0]);
    return w[31] ? -m : m;
  endfunction

  function automatic void verdict(input logic [31:0] q[$], output logic [4:0] cls,
                                  output logic [31:0] val, output logic nan);
    bit found = 0;
    nan = 1'b0;
    cls = 5'd0;
    val = relu(q[0]);
    for (int i = 0; i < q.size(); i++) begin
      logic [31:0] w;
      w = relu(q[i]);
      if (is_nan(w)) nan = 1'b1;
      else if (!found || fkey(w) > fkey(val)) begin
        found = 1;
        cls = 5'(i);
        val = w;
      end
    end
  endfunction

  always @(posedge clk) begin
    m_xfer = 1'b0;
    if (reset) begin
      frame_q.delete();
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_xfer = 1'b1;
        frame_q.push_back(in_data);
        if (frame_q.size() == NC) begin
          verdict(frame_q, m_cls, m_val, m_nan);
          frame_q.delete();
          m_hold = 1'b1;
        end
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", 32'(in_ready), 32'(!m_hold));
      chk("out_valid", 32'(out_valid), 32'(m_hold));
      if (m_hold) begin
        chk("out_class", 32'(out_class), 32'(m_cls));
        chk("out_value", out_value, m_val);
        chk("out_nan", 32'(out_nan), 32'(m_nan));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_words(input logic [31:0] w[NC], input bit gaps);
    for (int i = 0; i < NC; i++) begin
      if (gaps && (i % 3 == 1)) begin
        in_valid = 1'b0;
        in_data  = 32'hDEADBEEF;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = w[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] w[NC], input int stall, input bit gaps,
                           input logic [4:0] ecls, input logic [31:0] eval, input logic enan);
    logic [31:0] held;
    out_ready = 1'b0;
    send_words(w, gaps);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lit_class", 32'(out_class), 32'(ecls));
    chk("lit_value", out_value, eval);
    chk("lit_nan", 32'(out_nan), 32'(enan));
    held = out_value;
    in_valid = 1'b1;
    in_data  = 32'h7F000000;
    repeat (stall) @(negedge clk);
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    chk("hold_value", out_value, held);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_value", out_value, 32'h0);
    chk("rel_class", 32'(out_class), 32'd0);
    chk("rel_nan", 32'(out_nan), 32'd0);
  endtask

  logic [31:0] fa[NC], fb[NC], fc[NC], fd[NC], fe[NC];
  logic [31:0] stream[3*NC];

  initial begin
    int ptr;
    reset = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    for (int i = 0; i < NC; i++) begin
      fa[i] = 32'h00000000;
      fb[i] = 32'hC0400000;
      fc[i] = (i == 2 || i == 7) ? 32'h40000000 : 32'h3F800000;
      fd[i] = (i == 0) ? 32'h7FC00000 : (i == 4) ? 32'h3F800000 : 32'hBF800000;
      fe[i] = (i == 0) ? 32'h80000000 : (i == 3) ? 32'h00000000 : 32'hBF800000;
    end
    fa[0] = 32'h3F800000; fa[1] = 32'h40000000; fa[2] = 32'h3F000000;
    for (int k = 0; k < 3*NC; k++)
      stream[k] = {1'(k % 4 == 3), 8'(120 + (k * 7) % 13), 23'(k * 1234)};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_class", 32'(out_class), 32'd0);
    chk("rst_value", out_value, 32'h0);
    chk("rst_nan", 32'(out_nan), 32'd0);
    @(posedge clk); #1;

    run_frame(fa, 0, 0, 5'd1, 32'h40000000, 1'b0);
`ifdef NN_ARGMAX_RELU_EN
    run_frame(fb, 0, 0, 5'd0, 32'h00000000, 1'b0);
    run_frame(fe, 2, 0, 5'd0, 32'h00000000, 1'b0);
`else
    run_frame(fb, 0, 0, 5'd0, 32'hC0400000, 1'b0);
    run_frame(fe, 2, 0, 5'd0, 32'h80000000, 1'b0);
`endif
    run_frame(fc, 1, 1, 5'd2, 32'h40000000, 1'b0);
    run_frame(fd, 20, 0, 5'd4, 32'h3F800000, 1'b1);

    // Continuous valid/ready: three frames in 3*(NC+1) cycles.
    ptr = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 3*(NC+1); c++) begin
      in_valid = (ptr < 3*NC);
      in_data  = (ptr < 3*NC) ? stream[ptr] : 32'h0;
      @(posedge clk); #1;
      if (m_xfer) ptr++;
    end
    chk("throughput_words", 32'(ptr), 32'(3*NC));
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset mid-frame, with a word offered on the reset edge.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h7F7FFFFF;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    run_frame(fa, 0, 0, 5'd1, 32'h40000000, 1'b0);

    // Reset while holding a verdict, with out_ready high on the reset edge.
    send_words(fd, 0);
    reset = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rsthold_out_valid", 32'(out_valid), 32'd0);
    chk("rsthold_value", out_value, 32'h0);
    chk("rsthold_nan", 32'(out_nan), 32'd0);
    run_frame(fc, 0, 0, 5'd2, 32'h40000000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nn_result_argmax.md
NN_RESULT_ARGMAX -- requirements
Module: nn_result_argmax

Interface
REQ-001 Parameter NUM_CLASSES, default 10; result words per frame, legal range 2..24.
REQ-002 Port clk, input, 1; single clock, all logic on rising edge.
REQ-003 Port reset, input, 1; synchronous, active-high.
REQ-004 Port in_valid, input, 1; upstream result word present.
REQ-005 Port in_data, input, 32; IEEE-754 single-precision result word from the MAC accelerator's result buffer.
REQ-006 Port in_ready, output, 1; block accepts in_data this cycle.
REQ-007 Port out_valid, output, 1; frame verdict available.
REQ-008 Port out_ready, input, 1; downstream consumes verdict.
REQ-009 Port out_class, output, 5; index (0-based) of maximum word in frame.
REQ-010 Port out_value, output, 32; maximum word (post-ReLU when enabled).
REQ-011 Port out_nan, output, 1; at least one NaN word occurred in frame.

Function
REQ-012 Word transfer occurs on any cycle with in_valid && in_ready; verdict transfer on out_valid && out_ready.
REQ-013 FSM states ACCUM and HOLD; reset enters ACCUM with word index 0.
REQ-014 ACCUM: in_ready=1, out_valid=0; each transfer increments 5-bit word index.
REQ-015 First word of frame (index 0) unconditionally loads running max and class 0.
REQ-016 Later word replaces running max only if strictly greater; ties keep the lower index.
REQ-017 Compare is sign-magnitude: positive > negative; positives by larger {exp,mant}; negatives by smaller {exp,mant}; +0 equals -0.
REQ-018 NaN (exp=8'hFF, mant!=0) compares less than every non-NaN, never replaces the max, and sets the frame NaN flag; a NaN at index 0 is replaced by the first later non-NaN.
REQ-019 Transfer at index NUM_CLASSES-1 moves FSM to HOLD next cycle; index returns to 0.
REQ-020 HOLD: out_valid=1, in_ready=0; out_class/out_value/out_nan stable until verdict transfer.
REQ-021 Verdict transfer returns FSM to ACCUM next cycle; running max and NaN flag clear.
REQ-022 Latency: out_valid rises exactly 1 cycle after the last word's transfer cycle.
REQ-023 in_valid low in ACCUM stalls without state change; no word is lost or duplicated.
REQ-024 out_ready held low in HOLD stalls indefinitely; upstream is back-pressured via in_ready=0.
REQ-025 Throughput: one frame per NUM_CLASSES+1 cycles minimum with continuous valid/ready.

Reset
REQ-026 Reset in any state, including mid-frame or HOLD, discards partial frame in the same edge.
REQ-027 Reset values: in_ready=1, out_valid=0, out_class=0, out_value=32'h0, out_nan=0, index=0.
REQ-028 Reset dominates a simultaneous word or verdict transfer.

Configuration
REQ-029 Macro NN_ARGMAX_RELU_EN defined: any non-NaN word with sign=1 is replaced by +0 (32'h0) before compare and reporting.
REQ-030 Macro NN_ARGMAX_RELU_EN undefined: words compared and reported unmodified; negative maxima possible.

Verification
REQ-031 Frame 3F800000,40000000,3F000000,then seven 00000000, out_ready=1 -> out_class=1, out_value=40000000, out_nan=0, out_valid 1 cycle after 10th word.
REQ-032 Frame all C0400000 (-3.0), out_ready=1 -> without RELU: class 0, value C0400000; with RELU: class 0, value 00000000.
REQ-033 Frame with 40000000 at indices 2 and 7, others 3F800000 -> out_class=2 (tie keeps lower).
REQ-034 Frame word0=7FC00000, word4=3F800000, others BF800000, no RELU -> class 4, value 3F800000, out_nan=1.
REQ-035 Hold out_ready=0 for 20 cycles after verdict -> in_ready=0, outputs stable throughout; releasing yields one transfer then in_ready=1.
REQ-036 Assert reset after 5 words of a frame, then send a full new frame -> verdict reflects only the new frame.
